// File: rtl/jtpopeye_romarb_pkg.sv
// ============================================================================
// jtpopeye_romarb_pkg
// Shared types and constants for the Popeye ROM arbiter.
//   state_t      : arbiter FSM states (idle / waiting for SDRAM)
//   CL_OBJ/CL_SCR: client identifiers used for grant and round-robin pointer
//   DEF_*        : default SDRAM width and ROM base offsets
// ============================================================================
package jtpopeye_romarb_pkg;

   // Arbiter states: IDLE looks for a pending client, WAIT holds the request
   // until the SDRAM controller answers.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Client identifiers, also the encoding of the round-robin pointer.
   localparam logic CL_OBJ = 1'b0;
   localparam logic CL_SCR = 1'b1;

   // Default SDRAM word-address width and ROM base offsets.
   localparam int          DEF_SDW     = 22;
   localparam logic [21:0] DEF_OBJ_OFF = 22'h10000;
   localparam logic [21:0] DEF_SCR_OFF = 22'h14000;

endpackage

// File: rtl/jtpopeye_romarb_slot.sv
// ============================================================================
// jtpopeye_romarb_slot
// One client slot of the ROM arbiter: remembers which address was last
// fetched, whether the fetched word has arrived, and the word itself.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_addr            : client's current 13-bit ROM word address
//   i_load_addr       : FSM strobe, fetch for i_addr starts this cycle
//   i_load_data       : FSM strobe, i_sdram_data is this slot's word
//   i_sdram_data      : SDRAM read data
//   o_data            : last word returned for this slot
//   o_ok              : o_data belongs to the current i_addr
//   o_pending         : slot needs a (re)fetch
// ============================================================================
module jtpopeye_romarb_slot (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [12:0] i_addr,
   input  logic        i_load_addr,
   input  logic        i_load_data,
   input  logic [31:0] i_sdram_data,
   output logic [31:0] o_data,
   output logic        o_ok,
   output logic        o_pending
);

   logic [12:0] r_cachedAddr;
   logic        r_valid;
   logic [31:0] r_data;
   logic        w_match;

   // Starting a fetch records the requested address and marks the slot as
   // not yet valid; the returning word then makes it valid. The two strobes
   // never coincide because the FSM issues them from different states.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cachedAddr <= 13'd0;
         r_valid      <= 1'b0;
         r_data       <= 32'd0;
      end else if (i_load_addr) begin
         r_cachedAddr <= i_addr;
         r_valid      <= 1'b0;
      end else if (i_load_data) begin
         r_data  <= i_sdram_data;
         r_valid <= 1'b1;
      end
   end

   // The address compare is combinational so that ok drops in the very cycle
   // the client moves to a new address, and a word fetched for an address the
   // client has already left never shows up as valid.
   always_comb begin
      w_match   = (i_addr == r_cachedAddr);
      o_ok      = r_valid && w_match;
      o_pending = !r_valid || !w_match;
      o_data    = r_data;
   end

endmodule

// File: rtl/jtpopeye_romarb.sv
// ============================================================================
// jtpopeye_romarb
// Shares one SDRAM read port between the object ROM fetcher and the scroll
// ROM fetcher. Each address change produces exactly one SDRAM read; the
// returned word is held with an ok flag until the client moves on.
// Ports:
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_obj_addr / o_obj_data  : object ROM word address / returned word
//   o_obj_ok                 : o_obj_data valid for current i_obj_addr
//   i_scr_addr / o_scr_data  : scroll ROM word address / returned word
//   o_scr_ok                 : o_scr_data valid for current i_scr_addr
//   o_sdram_req              : read request, held until i_sdram_rdy
//   o_sdram_addr             : read address, stable while o_sdram_req
//   i_sdram_rdy              : one-cycle pulse, i_sdram_data valid
//   i_sdram_data             : SDRAM read data
// ============================================================================
module jtpopeye_romarb
   import jtpopeye_romarb_pkg::*;
#(
   parameter int             SDW     = DEF_SDW,
   parameter logic [SDW-1:0] OBJ_OFF = SDW'(DEF_OBJ_OFF),
   parameter logic [SDW-1:0] SCR_OFF = SDW'(DEF_SCR_OFF)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [12:0]    i_obj_addr,
   output logic [31:0]    o_obj_data,
   output logic           o_obj_ok,
   input  logic [12:0]    i_scr_addr,
   output logic [31:0]    o_scr_data,
   output logic           o_scr_ok,
   output logic           o_sdram_req,
   output logic [SDW-1:0] o_sdram_addr,
   input  logic           i_sdram_rdy,
   input  logic [31:0]    i_sdram_data
);

   state_t         r_state;
   logic           r_grant;
   logic           r_rr;
   logic           w_objPend;
   logic           w_scrPend;
   logic           w_anyPend;
   logic           w_bothPend;
   logic           w_pick;
   logic [SDW-1:0] w_pickAddr;
   logic           w_objLoadAddr;
   logic           w_scrLoadAddr;
   logic           w_objLoadData;
   logic           w_scrLoadData;

   // Object ROM slot.
   jtpopeye_romarb_slot u_objSlot (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_addr       (i_obj_addr),
      .i_load_addr  (w_objLoadAddr),
      .i_load_data  (w_objLoadData),
      .i_sdram_data (i_sdram_data),
      .o_data       (o_obj_data),
      .o_ok         (o_obj_ok),
      .o_pending    (w_objPend)
   );

   // Scroll ROM slot.
   jtpopeye_romarb_slot u_scrSlot (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_addr       (i_scr_addr),
      .i_load_addr  (w_scrLoadAddr),
      .i_load_data  (w_scrLoadData),
      .i_sdram_data (i_sdram_data),
      .o_data       (o_scr_data),
      .o_ok         (o_scr_ok),
      .o_pending    (w_scrPend)
   );

   // Grant selection: a lone pending client wins outright, a tie goes to the
   // round-robin pointer. The SDRAM address is the client's ROM base plus
   // its zero-extended word address, wrapping silently at SDW bits.
   // Load strobes tell the slots when a fetch starts (IDLE grant) and when
   // its data arrives (rdy while waiting); a stray rdy in IDLE loads nothing.
   always_comb begin
      w_anyPend  = w_objPend || w_scrPend;
      w_bothPend = w_objPend && w_scrPend;
      w_pick     = w_bothPend ? r_rr : (w_objPend ? CL_OBJ : CL_SCR);
      w_pickAddr = (w_pick == CL_OBJ) ? OBJ_OFF + SDW'(i_obj_addr)
                                      : SCR_OFF + SDW'(i_scr_addr);
      w_objLoadAddr = (r_state == ST_IDLE) && w_anyPend && (w_pick == CL_OBJ);
      w_scrLoadAddr = (r_state == ST_IDLE) && w_anyPend && (w_pick == CL_SCR);
      w_objLoadData = (r_state == ST_WAIT) && i_sdram_rdy && (r_grant == CL_OBJ);
      w_scrLoadData = (r_state == ST_WAIT) && i_sdram_rdy && (r_grant == CL_SCR);
   end

   // Arbiter FSM. IDLE issues a registered request for the chosen client and
   // remembers who was granted; the pointer only moves when both clients
   // contended, so the loser is always the next one served. WAIT holds the
   // request and address steady until the SDRAM answers, then drops back to
   // IDLE, which leaves one idle cycle between consecutive fetches.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         o_sdram_req  <= 1'b0;
         o_sdram_addr <= '0;
         r_grant      <= CL_OBJ;
         r_rr         <= CL_OBJ;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_anyPend) begin
                  o_sdram_req  <= 1'b1;
                  o_sdram_addr <= w_pickAddr;
                  r_grant      <= w_pick;
                  if (w_bothPend) begin
                     r_rr <= ~w_pick;
                  end
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_sdram_rdy) begin
                  o_sdram_req <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               o_sdram_req <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtpopeye_romarb.sv
// ============================================================================
// tb_jtpopeye_romarb
// Self-checking bench for jtpopeye_romarb: a per-cycle vector table covering
// reset, single and contended fetches, address change mid-fetch, stray rdy
// and reset mid-fetch, followed by a hand-written idle-hold sequence and
// background protocol monitors.
// ============================================================================
module tb_jtpopeye_romarb;

   typedef struct {
      logic        rst;
      logic [12:0] oa;
      logic [12:0] sa;
      logic        rdy;
      logic [31:0] din;
      logic        req;
      logic [21:0] saddr;
      logic        ook;
      logic        sok;
      logic [31:0] od;
      logic [31:0] sd;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [12:0] objAddr;
   logic [31:0] objData;
   logic        objOk;
   logic [12:0] scrAddr;
   logic [31:0] scrData;
   logic        scrOk;
   logic        sdramReq;
   logic [21:0] sdramAddr;
   logic        sdramRdy;
   logic [31:0] sdramData;

   int nCompared;
   int nFailed;
   vec_t vecs[28];

   jtpopeye_romarb dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_obj_addr   (objAddr),
      .o_obj_data   (objData),
      .o_obj_ok     (objOk),
      .i_scr_addr   (scrAddr),
      .o_scr_data   (scrData),
      .o_scr_ok     (scrOk),
      .o_sdram_req  (sdramReq),
      .o_sdram_addr (sdramAddr),
      .i_sdram_rdy  (sdramRdy),
      .i_sdram_data (sdramData)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds one vector record.
   function automatic vec_t mkVec(input logic r, input logic [12:0] oa, input logic [12:0] sa,
                                  input logic rdy, input logic [31:0] din, input logic req,
                                  input logic [21:0] saddr, input logic ook, input logic sok,
                                  input logic [31:0] od, input logic [31:0] sd);
      vec_t v;
      v.rst = r; v.oa = oa; v.sa = sa; v.rdy = rdy; v.din = din;
      v.req = req; v.saddr = saddr; v.ook = ook; v.sok = sok; v.od = od; v.sd = sd;
      return v;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the DUT inputs for one vector.
   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      objAddr   = v.oa;
      scrAddr   = v.sa;
      sdramRdy  = v.rdy;
      sdramData = v.din;
   endtask

   // One comparison: counts it and reports a failure line if it differs.
   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Single-cycle rdy pulse carrying d.
   task automatic pulseRdy(input logic [31:0] d);
      sdramRdy  = 1'b1;
      sdramData = d;
      tick();
      sdramRdy  = 1'b0;
      sdramData = 32'd0;
   endtask

   // Waits a bounded number of cycles for a request; an expired bound is a failure.
   task automatic waitReq(input int bound, input int idx);
      int seen;
      seen = 0;
      for (int i = 0; i < bound; i++) begin
         if (sdramReq) begin
            seen = 1;
            break;
         end
         tick();
      end
      checkOutput("waitReq", idx, 32'(seen), 32'd1);
   endtask

   // Protocol monitor: after an edge where rdy was high the request must be
   // low, and a request held across an edge outside reset keeps its address.
   always begin
      logic        rdyAtEdge;
      logic        rstAtEdge;
      logic        reqBefore;
      logic [21:0] addrBefore;
      @(posedge clk);
      rdyAtEdge  = sdramRdy;
      rstAtEdge  = rst;
      reqBefore  = sdramReq;
      addrBefore = sdramAddr;
      @(negedge clk);
      if (rdyAtEdge) begin
         checkOutput("monReqAfterRdy", 0, 32'(sdramReq), 32'd0);
      end
      if (!rstAtEdge && reqBefore && sdramReq) begin
         checkOutput("monAddrStable", 0, 32'(sdramAddr), 32'(addrBefore));
      end
   end

   // Main sequence: vector table, then idle-hold bandwidth check.
   initial begin
      int rises;
      logic prevReq;
      nCompared = 0;
      nFailed   = 0;

      vecs[0]  = mkVec(1, 13'h5, 13'h0, 0, 32'h0,        0, 22'h0,     0, 0, 32'h0,        32'h0);
      vecs[1]  = mkVec(1, 13'h5, 13'h0, 0, 32'h0,        0, 22'h0,     0, 0, 32'h0,        32'h0);
      vecs[2]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        1, 22'h10005, 0, 0, 32'h0,        32'h0);
      vecs[3]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        1, 22'h10005, 0, 0, 32'h0,        32'h0);
      vecs[4]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        1, 22'h10005, 0, 0, 32'h0,        32'h0);
      vecs[5]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        1, 22'h10005, 0, 0, 32'h0,        32'h0);
      vecs[6]  = mkVec(0, 13'h5, 13'h0, 1, 32'hDEADBEEF, 0, 22'h10005, 1, 0, 32'hDEADBEEF, 32'h0);
      vecs[7]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        1, 22'h14000, 1, 0, 32'hDEADBEEF, 32'h0);
      vecs[8]  = mkVec(0, 13'h5, 13'h0, 1, 32'h0000CAFE, 0, 22'h14000, 1, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[9]  = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        0, 22'h14000, 1, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[10] = mkVec(0, 13'h5, 13'h0, 1, 32'h12345678, 0, 22'h14000, 1, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[11] = mkVec(0, 13'h5, 13'h0, 0, 32'h0,        0, 22'h14000, 1, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[12] = mkVec(0, 13'h9, 13'h0, 0, 32'h0,        1, 22'h10009, 0, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[13] = mkVec(0, 13'h6, 13'h0, 0, 32'h0,        1, 22'h10009, 0, 1, 32'hDEADBEEF, 32'h0000CAFE);
      vecs[14] = mkVec(0, 13'h6, 13'h0, 1, 32'h11111111, 0, 22'h10009, 0, 1, 32'h11111111, 32'h0000CAFE);
      vecs[15] = mkVec(0, 13'h6, 13'h0, 0, 32'h0,        1, 22'h10006, 0, 1, 32'h11111111, 32'h0000CAFE);
      vecs[16] = mkVec(0, 13'h6, 13'h0, 1, 32'h22222222, 0, 22'h10006, 1, 1, 32'h22222222, 32'h0000CAFE);
      vecs[17] = mkVec(1, 13'h1, 13'h2, 0, 32'h0,        0, 22'h0,     0, 0, 32'h0,        32'h0);
      vecs[18] = mkVec(0, 13'h1, 13'h2, 0, 32'h0,        1, 22'h10001, 0, 0, 32'h0,        32'h0);
      vecs[19] = mkVec(0, 13'h1, 13'h2, 1, 32'hAAAA0001, 0, 22'h10001, 1, 0, 32'hAAAA0001, 32'h0);
      vecs[20] = mkVec(0, 13'h1, 13'h2, 0, 32'h0,        1, 22'h14002, 1, 0, 32'hAAAA0001, 32'h0);
      vecs[21] = mkVec(0, 13'h1, 13'h2, 1, 32'hBBBB0002, 0, 22'h14002, 1, 1, 32'hAAAA0001, 32'hBBBB0002);
      vecs[22] = mkVec(0, 13'h3, 13'h4, 0, 32'h0,        1, 22'h14004, 0, 0, 32'hAAAA0001, 32'hBBBB0002);
      vecs[23] = mkVec(0, 13'h3, 13'h4, 1, 32'hCCCC0004, 0, 22'h14004, 0, 1, 32'hAAAA0001, 32'hCCCC0004);
      vecs[24] = mkVec(0, 13'h3, 13'h4, 0, 32'h0,        1, 22'h10003, 0, 1, 32'hAAAA0001, 32'hCCCC0004);
      vecs[25] = mkVec(1, 13'h3, 13'h4, 0, 32'h0,        0, 22'h0,     0, 0, 32'h0,        32'h0);
      vecs[26] = mkVec(1, 13'h3, 13'h4, 1, 32'h12345678, 0, 22'h0,     0, 0, 32'h0,        32'h0);
      vecs[27] = mkVec(0, 13'h3, 13'h4, 0, 32'h0,        1, 22'h10003, 0, 0, 32'h0,        32'h0);

      $display("[TB] vector table: %0d steps", 28);
      for (int i = 0; i < 28; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput("req",      i, 32'(sdramReq),  32'(vecs[i].req));
         checkOutput("sdramAddr",i, 32'(sdramAddr), 32'(vecs[i].saddr));
         checkOutput("objOk",    i, 32'(objOk),     32'(vecs[i].ook));
         checkOutput("scrOk",    i, 32'(scrOk),     32'(vecs[i].sok));
         checkOutput("objData",  i, objData,        vecs[i].od);
         checkOutput("scrData",  i, scrData,        vecs[i].sd);
      end

      // Finish the object fetch left open by the table, then the scroll fetch.
      $display("[TB] hold sequence");
      sdramRdy  = 1'b0;
      sdramData = 32'd0;
      pulseRdy(32'h33330003);
      checkOutput("holdObjData", 100, objData, 32'h33330003);
      checkOutput("holdObjOk",   100, 32'(objOk), 32'd1);
      waitReq(8, 101);
      checkOutput("holdScrAddr", 101, 32'(sdramAddr), 32'h14004);
      pulseRdy(32'h44440004);
      checkOutput("holdScrData", 102, scrData, 32'h44440004);
      checkOutput("holdScrOk",   102, 32'(scrOk), 32'd1);

      // Steady addresses for 100 cycles must not cost any further request.
      rises   = 0;
      prevReq = sdramReq;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (sdramReq && !prevReq) rises++;
         prevReq = sdramReq;
      end
      checkOutput("holdReqRises", 103, 32'(rises), 32'd0);
      checkOutput("holdObjOkEnd", 103, 32'(objOk), 32'd1);
      checkOutput("holdScrOkEnd", 103, 32'(scrOk), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
